// File: rtl/tipi_nib_sequencer_if.sv
// Nibble-bus and register-file signal bundle for tipi_nib_sequencer.
// master = Pi/register-file side that drives the inputs, slave = sequencer.
// All signals are plain wires; no logic lives here.
interface tipi_nib_sequencer_if;
  logic       r_clk;
  logic       r_nibrst;
  logic [3:0] r_nib_in;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic [7:0] td_q;
  logic [7:0] tc_q;
  logic [7:0] rd_d;
  logic       rd_we;
  logic [7:0] rc_d;
  logic       rc_we;
  logic       busy;
  logic       err;

  modport master (
    output r_clk, r_nibrst, r_nib_in, td_q, tc_q,
    input  r_nib_out, r_nib_oe, rd_d, rd_we, rc_d, rc_we, busy, err
  );

  modport slave (
    input  r_clk, r_nibrst, r_nib_in, td_q, tc_q,
    output r_nib_out, r_nib_oe, rd_d, rd_we, rc_d, rc_we, busy, err
  );
endinterface

// File: rtl/tipi_nib_sequencer.sv
// Sequences the Pi nibble bus against the TIPI TD/TC/RD/RC registers in the clk domain.
// Latency: an r_clk edge acts SYNC_STAGES+1 clk after the pin edge; write strobe 1 clk after the last nibble edge.
// No backpressure: the Pi paces the bus; a stalled transaction is aborted by the watchdog.
// Optional feature: define TIPI_NIB_CKSUM_EN for a trailing hi^lo checksum nibble on writes and reads.
module tipi_nib_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic                clk,
  input  logic                rst,
  tipi_nib_sequencer_if.slave bus
);

`ifdef TIPI_NIB_CKSUM_EN
  typedef enum logic [3:0] {
    IDLE, CMD, WR_HI, WR_LO, WR_CK, RD_HI, RD_LO, RD_CK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CMD, WR_HI, WR_LO, RD_HI, RD_LO, DONE
  } state_t;
`endif

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] nibrst_sync;
  logic                   clk_prev;
  logic                   r_clk_s;
  logic                   nibrst_s;
  logic                   rise;
  logic                   fall;

  state_t                 state;
  logic [TIMEOUT_W-1:0]   wd;
  logic [7:0]             snap;
  logic [3:0]             hi;
`ifdef TIPI_NIB_CKSUM_EN
  logic [3:0]             lo;
`endif
  logic                   sel_rc;
  logic                   busy_w;
  logic                   rd_phase;

  logic [3:0]             nib_out;
  logic                   nib_oe;
  logic [7:0]             rd_d_q;
  logic                   rd_we_q;
  logic [7:0]             rc_d_q;
  logic                   rc_we_q;
  logic                   err_q;

  // Synchronise the Pi strobes; the extra clk_prev flop gives edge detection on clean levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync    <= '0;
      nibrst_sync <= '0;
      clk_prev    <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], bus.r_clk};
      nibrst_sync <= {nibrst_sync[SYNC_STAGES-2:0], bus.r_nibrst};
      clk_prev    <= r_clk_s;
    end
  end

  assign r_clk_s  = clk_sync[SYNC_STAGES-1];
  assign nibrst_s = nibrst_sync[SYNC_STAGES-1];
  assign rise     = r_clk_s & ~clk_prev;
  assign fall     = ~r_clk_s & clk_prev;

`ifdef TIPI_NIB_CKSUM_EN
  assign busy_w   = (state == WR_HI) || (state == WR_LO) || (state == WR_CK) ||
                    (state == RD_HI) || (state == RD_LO) || (state == RD_CK);
  assign rd_phase = (state == RD_HI) || (state == RD_LO) || (state == RD_CK);
`else
  assign busy_w   = (state == WR_HI) || (state == WR_LO) ||
                    (state == RD_HI) || (state == RD_LO);
  assign rd_phase = (state == RD_HI) || (state == RD_LO);
`endif

  // Transaction FSM with registered bus/register outputs and the inter-edge watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wd      <= '0;
      snap    <= '0;
      hi      <= '0;
`ifdef TIPI_NIB_CKSUM_EN
      lo      <= '0;
`endif
      sel_rc  <= 1'b0;
      nib_out <= '0;
      nib_oe  <= 1'b0;
      rd_d_q  <= '0;
      rd_we_q <= 1'b0;
      rc_d_q  <= '0;
      rc_we_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_we_q <= 1'b0;
      rc_we_q <= 1'b0;
      err_q   <= 1'b0;
      if (nibrst_s) begin
        // Transaction reset wins over any r_clk edge and aborts silently.
        state  <= CMD;
        nib_oe <= 1'b0;
        wd     <= '0;
      end else begin
        if (rise || fall || !busy_w) wd <= '0;
        else                         wd <= wd + 1'b1;

        if (busy_w && !(rise || fall) && (wd == WD_LAST)) begin
          err_q  <= 1'b1;
          nib_oe <= 1'b0;
          state  <= IDLE;
        end else begin
          // The CPLD only takes the bus once the Pi has released it on a falling edge.
          if (fall && rd_phase) nib_oe <= 1'b1;

          if (rise) begin
            case (state)
              CMD: begin
                case (bus.r_nib_in)
                  4'h0: begin snap <= bus.td_q; state <= RD_HI; end
                  4'h1: begin snap <= bus.tc_q; state <= RD_HI; end
                  4'h2: begin sel_rc <= 1'b0;   state <= WR_HI; end
                  4'h3: begin sel_rc <= 1'b1;   state <= WR_HI; end
                  default: begin err_q <= 1'b1; state <= DONE; end
                endcase
              end
              WR_HI: begin
                hi    <= bus.r_nib_in;
                state <= WR_LO;
              end
`ifdef TIPI_NIB_CKSUM_EN
              WR_LO: begin
                lo    <= bus.r_nib_in;
                state <= WR_CK;
              end
              WR_CK: begin
                if (bus.r_nib_in == (hi ^ lo)) begin
                  if (sel_rc) begin rc_d_q <= {hi, lo}; rc_we_q <= 1'b1; end
                  else        begin rd_d_q <= {hi, lo}; rd_we_q <= 1'b1; end
                end else begin
                  err_q <= 1'b1;
                end
                state <= DONE;
              end
              RD_LO: begin
                nib_out <= snap[3:0];
                state   <= RD_CK;
              end
              RD_CK: begin
                nib_out <= snap[7:4] ^ snap[3:0];
                state   <= DONE;
              end
`else
              WR_LO: begin
                if (sel_rc) begin rc_d_q <= {hi, bus.r_nib_in}; rc_we_q <= 1'b1; end
                else        begin rd_d_q <= {hi, bus.r_nib_in}; rd_we_q <= 1'b1; end
                state <= DONE;
              end
              RD_LO: begin
                nib_out <= snap[3:0];
                state   <= DONE;
              end
`endif
              RD_HI: begin
                nib_out <= snap[7:4];
                state   <= RD_LO;
              end
              default: ; // IDLE and DONE ignore r_clk edges
            endcase
          end
        end
      end
    end
  end

  assign bus.r_nib_out = nib_out;
  assign bus.r_nib_oe  = nib_oe;
  assign bus.rd_d      = rd_d_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.rc_d      = rc_d_q;
  assign bus.rc_we     = rc_we_q;
  assign bus.busy      = busy_w;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tipi_nib_sequencer.sv
// Directed bench for tipi_nib_sequencer: Pi-side nibble transactions with a write scoreboard.
// Expected register writes are queued when stimulus is driven and popped when a strobe appears.
// Builds with or without TIPI_NIB_CKSUM_EN.
module tb_tipi_nib_sequencer;
  localparam int TO = 200;

  logic clk;
  logic rst;
  tipi_nib_sequencer_if bus ();

  tipi_nib_sequencer #(.SYNC_STAGES(2), .TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_rc;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pi_reset();
    bus.r_nibrst = 1'b1;
    wait_clk(6);
    bus.r_nibrst = 1'b0;
    wait_clk(6);
  endtask

  task automatic pi_rise(input logic [3:0] v);
    bus.r_nib_in = v;
    wait_clk(2);
    bus.r_clk = 1'b1;
    wait_clk(6);
  endtask

  task automatic pi_fall();
    bus.r_clk = 1'b0;
    wait_clk(6);
  endtask

  task automatic send_nib(input logic [3:0] v);
    pi_rise(v);
    pi_fall();
  endtask

  // Full write transaction including the checksum nibble when enabled; queues the expected strobe.
  task automatic wr(input logic is_rc, input logic [7:0] d);
    exp_t e;
    e.is_rc = is_rc;
    e.d     = d;
    sb.push_back(e);
    pi_reset();
    send_nib(is_rc ? 4'h3 : 4'h2);
    send_nib(d[7:4]);
    send_nib(d[3:0]);
`ifdef TIPI_NIB_CKSUM_EN
    send_nib(d[7:4] ^ d[3:0]);
`endif
    wait_clk(4);
  endtask

  // Scoreboard: every strobe must match the head of the queue; a 2-clk strobe shows up as an extra one.
  always @(negedge clk) begin
    if (!rst && (bus.rd_we || bus.rc_we)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({bus.rc_we, bus.rd_we}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_sel", 32'({bus.rc_we, bus.rd_we}), e.is_rc ? 32'd2 : 32'd1);
        chk("strobe_dat", 32'(e.is_rc ? bus.rc_d : bus.rd_d), 32'(e.d));
      end
    end
    if (!rst && bus.err) err_cnt++;
  end

  // Read transaction: command edge, two data edges (three with checksum), then a DONE edge.
  task automatic rd_check(input logic [3:0] cmd, input logic [7:0] val, input string tag);
    pi_reset();
    pi_rise(cmd);
    chk({tag, "_oe_before_fall"}, 32'(bus.r_nib_oe), 32'd0);
    if (cmd == 4'h1) bus.tc_q = 8'h00;
    else             bus.td_q = 8'h00;
    pi_fall();
    chk({tag, "_oe"}, 32'(bus.r_nib_oe), 32'd1);
    pi_rise(4'h0);
    chk({tag, "_hi"}, 32'(bus.r_nib_out), 32'(val[7:4]));
    pi_fall();
    pi_rise(4'h0);
    chk({tag, "_lo"}, 32'(bus.r_nib_out), 32'(val[3:0]));
    pi_fall();
`ifdef TIPI_NIB_CKSUM_EN
    pi_rise(4'h0);
    chk({tag, "_ck"}, 32'(bus.r_nib_out), 32'(val[7:4] ^ val[3:0]));
    pi_fall();
    pi_rise(4'h0);
    chk({tag, "_done_hold"}, 32'(bus.r_nib_out), 32'(val[7:4] ^ val[3:0]));
`else
    pi_rise(4'h0);
    chk({tag, "_done_hold"}, 32'(bus.r_nib_out), 32'(val[3:0]));
`endif
    chk({tag, "_done_oe"}, 32'(bus.r_nib_oe), 32'd1);
    chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
    pi_fall();
    pi_reset();
    chk({tag, "_oe_released"}, 32'(bus.r_nib_oe), 32'd0);
  endtask

  initial begin
    int e0;
    rst          = 1'b1;
    bus.r_clk    = 1'b0;
    bus.r_nibrst = 1'b0;
    bus.r_nib_in = 4'h0;
    bus.td_q     = 8'h00;
    bus.tc_q     = 8'h00;
    wait_clk(3);
    // 1: reset state
    chk("rst_nib_out", 32'(bus.r_nib_out), 32'd0);
    chk("rst_oe", 32'(bus.r_nib_oe), 32'd0);
    chk("rst_outs", 32'({bus.rd_d, bus.rc_d, bus.rd_we, bus.rc_we, bus.busy, bus.err}), 32'd0);
    rst = 1'b0;
    wait_clk(3);
    // r_clk activity before any nibrst is ignored (IDLE)
    send_nib(4'h2);
    send_nib(4'ha);
    send_nib(4'h5);
    send_nib(4'h5);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_rd_d", 32'(bus.rd_d), 32'd0);

    // 2: RD write
    wr(1'b0, 8'ha5);
    chk("wr_rd_d", 32'(bus.rd_d), 32'ha5);
    chk("wr_rd_rc_unchanged", 32'(bus.rc_d), 32'd0);
    // 3: RC write
    wr(1'b1, 8'h6b);
    chk("wr_rc_d", 32'(bus.rc_d), 32'h6b);
    wr(1'b0, 8'h3c);
    chk("wr_rd2_rc_unchanged", 32'(bus.rc_d), 32'h6b);
    chk("wr_rd2_d", 32'(bus.rd_d), 32'h3c);

    // 4: reads, snapshot must not tear when the latch changes after the command edge
    bus.tc_q = 8'h55;
    rd_check(4'h1, 8'h55, "rd_tc");
    bus.td_q = 8'ha5;
    rd_check(4'h0, 8'ha5, "rd_td");

    // 5a: timeout mid-write
    e0 = err_cnt;
    pi_reset();
    send_nib(4'h2);
    send_nib(4'ha);
    chk("to_busy_before", 32'(bus.busy), 32'd1);
    wait_clk(TO + 20);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_busy_after", 32'(bus.busy), 32'd0);
    chk("to_oe", 32'(bus.r_nib_oe), 32'd0);
    // back in IDLE: a full write without nibrst must not strobe
    send_nib(4'h2);
    send_nib(4'ha);
    send_nib(4'h5);
    send_nib(4'hf);
    chk("to_idle_rd_d", 32'(bus.rd_d), 32'h3c);

    // 5b: nibrst abort is silent and lands in CMD
    e0 = err_cnt;
    pi_reset();
    send_nib(4'h2);
    send_nib(4'ha);
    pi_reset();
    chk("abort_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    begin
      exp_t e;
      e.is_rc = 1'b1;
      e.d     = 8'h9e;
      sb.push_back(e);
    end
    send_nib(4'h3);
    send_nib(4'h9);
    send_nib(4'he);
`ifdef TIPI_NIB_CKSUM_EN
    send_nib(4'h9 ^ 4'he);
`endif
    wait_clk(4);
    chk("abort_cmd_rc_d", 32'(bus.rc_d), 32'h9e);

    // 6: bad command
    e0 = err_cnt;
    pi_reset();
    send_nib(4'h7);
    chk("badcmd_err", 32'(err_cnt - e0), 32'd1);
    chk("badcmd_oe", 32'(bus.r_nib_oe), 32'd0);
    chk("badcmd_busy", 32'(bus.busy), 32'd0);
    send_nib(4'h2);
    send_nib(4'h1);
    send_nib(4'h1);
    chk("badcmd_done_ignores", 32'(bus.rd_d), 32'h3c);

`ifdef TIPI_NIB_CKSUM_EN
    wr(1'b0, 8'ha5);
    chk("ck_good_rd_d", 32'(bus.rd_d), 32'ha5);
    e0 = err_cnt;
    pi_reset();
    send_nib(4'h2);
    send_nib(4'ha);
    send_nib(4'h5);
    send_nib(4'h0);
    wait_clk(4);
    chk("ck_bad_err", 32'(err_cnt - e0), 32'd1);
    chk("ck_bad_rd_d", 32'(bus.rd_d), 32'ha5);
`endif

    wait_clk(10);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
